frame_buffer_ring: RTL and testbench

Parametrised N-way display frame store, replacing the fixed two-buffer display mux. Port A is the read-only VGA scan-out port on the current display buffer. Port B is the read-write renderer port on the current draw buffer. Buffers rotate round-robin at frame boundaries, the swap request from the renderer is latched so it need not coincide with end-of-frame, and the newly assigned draw buffer can be cleared in hardware.

---
 rtl/frame_buffer_ring.sv | 129 ++++++++++++
 tb/tb_frame_buffer_ring.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_ring.sv
// frame_buffer_ring: N-way rotating frame store. Port A scans out the display buffer, port B
// renders into the draw buffer; buffers rotate on a latched swap and the new draw buffer can be cleared.
module frame_buffer_ring #(
   parameter int unsigned        PIXEL_W      = 12,
   parameter int unsigned        ADDR_X_W     = 10,
   parameter int unsigned        ADDR_Y_W     = 9,
   parameter int unsigned        NUM_BUFFERS  = 3,
   parameter bit                 CLEAR_ENABLE = 1'b1,
   parameter logic [PIXEL_W-1:0] CLEAR_VALUE  = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_X_W-1:0] address_a_x,
   input  logic [ADDR_Y_W-1:0] address_a_y,
   output logic [PIXEL_W-1:0]  data_a,
   input  logic [ADDR_X_W-1:0] address_b_x,
   input  logic [ADDR_Y_W-1:0] address_b_y,
   input  logic                write_enable_b,
   input  logic [PIXEL_W-1:0]  write_data_b,
   output logic [PIXEL_W-1:0]  data_b,
   input  logic                vga_frame_complete,
   input  logic                tasks_complete,
   output logic                next_frame,
   output logic                draw_ready,
   output logic [1:0]          display_index,
   output logic [1:0]          draw_index
);

   localparam int unsigned PIX_AW    = ADDR_X_W + ADDR_Y_W;
   localparam int unsigned WORDS     = 1 << PIX_AW;
   localparam int unsigned MEM_DEPTH = NUM_BUFFERS * WORDS;
   localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
   localparam logic [1:0]  LAST_BUF  = 2'(NUM_BUFFERS - 1);

   typedef enum logic {StIdle, StClear} clear_state_e;

   clear_state_e        state_q;
   logic [PIX_AW-1:0]   clear_count_q;
   logic                tasks_pending_q;

   logic                swap;
   logic [1:0]          draw_next;
   logic [MEM_AW-1:0]   addr_a;
   logic [MEM_AW-1:0]   addr_b;
   logic [MEM_AW-1:0]   addr_clear;
   logic                wr_en;
   logic [MEM_AW-1:0]   wr_addr;
   logic [PIXEL_W-1:0]  wr_data;

   logic [PIXEL_W-1:0]  mem [MEM_DEPTH];

   // Buffer index is the top field; with two buffers its upper bit is always zero.
   assign addr_a     = MEM_AW'({display_index, address_a_y, address_a_x});
   assign addr_b     = MEM_AW'({draw_index, address_b_y, address_b_x});
   assign addr_clear = MEM_AW'({draw_index, clear_count_q});

   always_comb begin
      swap      = vga_frame_complete & (tasks_complete | tasks_pending_q) & draw_ready;
      draw_next = (draw_index == LAST_BUF) ? 2'd0 : draw_index + 2'd1;
      wr_en     = 1'b0;
      wr_addr   = addr_b;
      wr_data   = write_data_b;
      if (state_q == StClear) begin
         wr_en   = 1'b1;
         wr_addr = addr_clear;
         wr_data = CLEAR_VALUE;
      end else if (write_enable_b && draw_ready) begin
         wr_en = 1'b1;
      end
   end

   // Swap bookkeeping and clear sequencer; all outputs registered here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= StIdle;
         clear_count_q   <= '0;
         draw_ready      <= 1'b1;
         next_frame      <= 1'b0;
         display_index   <= 2'd0;
         draw_index      <= 2'd1;
         tasks_pending_q <= 1'b0;
      end else begin
         next_frame      <= swap;
         tasks_pending_q <= ~swap & (tasks_pending_q | tasks_complete);
         if (swap) begin
            display_index <= draw_index;
            draw_index    <= draw_next;
         end
         unique case (state_q)
            StIdle: begin
               if (swap && CLEAR_ENABLE) begin
                  state_q       <= StClear;
                  draw_ready    <= 1'b0;
                  clear_count_q <= '0;
               end
            end
            StClear: begin
               clear_count_q <= clear_count_q + PIX_AW'(1);
               if (&clear_count_q) begin
                  state_q    <= StIdle;
                  draw_ready <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_a <= '0;
         data_b <= '0;
      end else begin
         data_a <= mem[addr_a];
         data_b <= mem[addr_b];
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   distinct_indices_a : assert property (@(posedge clock) disable iff (reset)
      display_index != draw_index);

endmodule

// File: tb/tb_frame_buffer_ring.sv
// Bench for frame_buffer_ring: directed corner sequences, a frame-rotation table and a random run,
// all compared against a word-array reference model of the frame store.
module tb_frame_buffer_ring;

   logic        clock;
   logic        reset;
   logic [2:0]  ax;
   logic [1:0]  ay;
   logic [11:0] data_a;
   logic [2:0]  bx;
   logic [1:0]  by;
   logic        we;
   logic [11:0] wd;
   logic [11:0] data_b;
   logic        vfc;
   logic        tc;
   logic        next_frame;
   logic        draw_ready;
   logic [1:0]  display_index;
   logic [1:0]  draw_index;

   frame_buffer_ring #(
      .PIXEL_W      (12),
      .ADDR_X_W     (3),
      .ADDR_Y_W     (2),
      .NUM_BUFFERS  (3),
      .CLEAR_ENABLE (1'b1),
      .CLEAR_VALUE  (12'h000)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .address_a_x        (ax),
      .address_a_y        (ay),
      .data_a             (data_a),
      .address_b_x        (bx),
      .address_b_y        (by),
      .write_enable_b     (we),
      .write_data_b       (wd),
      .data_b             (data_b),
      .vga_frame_complete (vfc),
      .tasks_complete     (tc),
      .next_frame         (next_frame),
      .draw_ready         (draw_ready),
      .display_index      (display_index),
      .draw_index         (draw_index)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 3 buffers x 32 words, clear tracked as a remaining-word countdown.
   logic [11:0] m_mem   [96];
   bit          m_known [96];
   int          m_disp, m_draw, m_clear_left, m_clear_ptr;
   bit          m_pend, m_next, m_da_known, m_db_known;
   logic [11:0] m_da, m_db;

   typedef struct {
      int unsigned lead;
      logic [1:0]  exp_disp;
      logic [1:0]  exp_draw;
   } frame_vec_t;

   frame_vec_t frames [4];
   int         low_cycles;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_disp       = 0;
      m_draw       = 1;
      m_pend       = 1'b0;
      m_next       = 1'b0;
      m_clear_left = 0;
      m_clear_ptr  = 0;
      m_da         = 12'h000;
      m_db         = 12'h000;
      m_da_known   = 1'b1;
      m_db_known   = 1'b1;
   endtask

   task automatic model_step();
      int ia, ib, ic;
      bit ready, swap;
      ready = (m_clear_left == 0);
      ia = m_disp * 32 + int'(ay) * 8 + int'(ax);
      ib = m_draw * 32 + int'(by) * 8 + int'(bx);
      m_da       = m_mem[ia];
      m_da_known = m_known[ia];
      m_db       = m_mem[ib];
      m_db_known = m_known[ib];
      swap = vfc && (tc || m_pend) && ready;
      if (!ready) begin
         ic = m_draw * 32 + m_clear_ptr;
         m_mem[ic]   = 12'h000;
         m_known[ic] = 1'b1;
         m_clear_ptr++;
         m_clear_left--;
      end else if (we) begin
         m_mem[ib]   = wd;
         m_known[ib] = 1'b1;
      end
      m_pend = !swap && (m_pend || tc);
      m_next = swap;
      if (swap) begin
         m_disp       = m_draw;
         m_draw       = (m_draw + 1) % 3;
         m_clear_left = 32;
         m_clear_ptr  = 0;
      end
   endtask

   task automatic compare_model();
      check("next_frame", next_frame, m_next);
      check("draw_ready", draw_ready, (m_clear_left == 0) ? 1 : 0);
      check("display_index", display_index, m_disp);
      check("draw_index", draw_index, m_draw);
      if (m_da_known) check("data_a", data_a, m_da);
      if (m_db_known) check("data_b", data_b, m_db);
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset) model_reset();
      else model_step();
      #1;
      compare_model();
   endtask

   task automatic apply_reset();
      we    = 1'b0;
      tc    = 1'b0;
      vfc   = 1'b0;
      reset = 1'b1;
      model_reset();
      #1;
      check("reset_data_a", data_a, 12'h000);
      check("reset_data_b", data_b, 12'h000);
      check("reset_next_frame", next_frame, 0);
      check("reset_draw_ready", draw_ready, 1);
      check("reset_display_index", display_index, 0);
      check("reset_draw_index", draw_index, 1);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 200 && draw_ready !== 1'b1; i++) tick();
      check("draw_ready_timeout", draw_ready, 1);
   endtask

   // tasks_complete, then vga_frame_complete 'lead' cycles later (0 = same edge).
   task automatic do_frame(input int unsigned lead);
      tc = 1'b1;
      if (lead == 0) vfc = 1'b1;
      tick();
      tc  = 1'b0;
      vfc = 1'b0;
      if (lead != 0) begin
         repeat (lead - 1) tick();
         vfc = 1'b1;
         tick();
         vfc = 1'b0;
      end
   endtask

   initial begin
      frames[0] = '{lead: 4, exp_disp: 2'd1, exp_draw: 2'd2};
      frames[1] = '{lead: 0, exp_disp: 2'd2, exp_draw: 2'd0};
      frames[2] = '{lead: 1, exp_disp: 2'd0, exp_draw: 2'd1};
      frames[3] = '{lead: 7, exp_disp: 2'd1, exp_draw: 2'd2};
      for (int i = 0; i < 96; i++) begin
         m_mem[i]   = 12'h000;
         m_known[i] = 1'b0;
      end
      reset = 1'b0;
      ax = '0; ay = '0; bx = '0; by = '0;
      we = 1'b0; wd = '0; vfc = 1'b0; tc = 1'b0;
      #1;
      apply_reset();

      // Write then read back on port B.
      bx = 3'd5; by = 2'd2; wd = 12'hABC; we = 1'b1;
      tick();
      we = 1'b0;
      tick();
      check("t1_data_b", data_b, 12'hABC);
      check("t1_display_index", display_index, 0);
      check("t1_draw_index", draw_index, 1);

      // Latched task completion, swap ten cycles later.
      ax = 3'd5; ay = 2'd2;
      do_frame(10);
      check("t2_next_frame", next_frame, 1);
      check("t2_display_index", display_index, 1);
      check("t2_draw_index", draw_index, 2);
      check("t2_draw_ready_low", draw_ready, 0);
      low_cycles = 1;
      tick();
      check("t2_next_frame_once", next_frame, 0);
      check("t2_data_a", data_a, 12'hABC);

      // Clear duration; a write to an already-cleared word mid-clear is dropped.
      for (int i = 0; i < 100 && draw_ready == 1'b0; i++) begin
         low_cycles++;
         if (low_cycles == 15) begin
            we = 1'b1; bx = 3'd1; by = 2'd0; wd = 12'h123;
         end else begin
            we = 1'b0;
         end
         tick();
      end
      we = 1'b0;
      check("t3_clear_low_cycles", low_cycles, 32);
      for (int i = 0; i < 32; i++) begin
         bx = 3'(i % 8);
         by = 2'(i / 8);
         tick();
         check("t3_cleared_word", data_b, 12'h000);
      end

      // Frame ends without a finished task repeat the display buffer.
      for (int f = 0; f < 3; f++) begin
         vfc = 1'b1;
         tick();
         vfc = 1'b0;
         check("t4_no_swap", next_frame, 0);
         check("t4_display_held", display_index, 1);
         check("t4_draw_held", draw_index, 2);
         repeat (3) tick();
      end
      tc = 1'b1; vfc = 1'b1;
      tick();
      tc = 1'b0; vfc = 1'b0;
      check("t4_coincident_swap", next_frame, 1);
      check("t4_display_index", display_index, 2);
      check("t4_draw_index", draw_index, 0);
      wait_ready();

      // Round-robin rotation from reset.
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         do_frame(frames[k].lead);
         check("t5_next_frame", next_frame, 1);
         check("t5_display_index", display_index, frames[k].exp_disp);
         check("t5_draw_index", draw_index, frames[k].exp_draw);
         wait_ready();
      end

      // Fill buffer 0, rotate until it is the new draw buffer, then reset mid-clear.
      do_frame(2);
      wait_ready();
      for (int i = 0; i < 32; i++) begin
         bx = 3'(i % 8);
         by = 2'(i / 8);
         wd = 12'(12'h500 + i);
         we = 1'b1;
         tick();
      end
      we = 1'b0;
      do_frame(2);
      wait_ready();
      do_frame(2);
      wait_ready();
      do_frame(2);
      check("t6_clearing_buffer0", draw_index, 0);
      repeat (10) tick();
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         ax = 3'(i % 8);
         ay = 2'(i / 8);
         tick();
         check("t6_partial_clear", data_a, (i < 10) ? 32'h000 : 32'(12'h500 + i));
      end

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         we  = ($urandom_range(0, 3) == 0);
         wd  = 12'($urandom);
         ax  = 3'($urandom_range(0, 7));
         ay  = 2'($urandom_range(0, 3));
         bx  = 3'($urandom_range(0, 7));
         by  = 2'($urandom_range(0, 3));
         tc  = ($urandom_range(0, 9) == 0);
         vfc = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
